input_entry: RTL and testbench

INPUT_ENTRY -- requirements
Module: input_entry

---
 rtl/input_entry.sv | 144 ++++++++++++++
 tb/tb_input_entry.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_entry.sv
`default_nettype none
// +------------------------------------------------------------------+
// | input_entry: debounced four-digit BCD entry from switches/buttons |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module input_entry #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  sw,
  input  logic        btnEnter,
  input  logic        btnClear,
  output logic [15:0] userInput,
  output logic        inputReady,
  output logic [2:0]  digitCount,
  output logic        badDigit
);

  localparam logic [DB_W-1:0] c_db_last = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_pulse;
  logic       w_enter_p;
  logic       w_clear_p;

  assign w_raw = {btnClear, btnEnter};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_s1;
      logic            r_s2;
      logic            r_db;
      logic            r_pulse;
      logic [DB_W-1:0] r_cnt;

      // Pulse is raised in the same cycle the debounced level rises.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_db    <= 1'b0;
          r_pulse <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_s1    <= w_raw[gi];
          r_s2    <= r_s1;
          r_pulse <= 1'b0;
          if (r_s2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == c_db_last) begin
            r_db    <= r_s2;
            r_pulse <= r_s2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_pulse[gi] = r_pulse;
    end
  endgenerate

  assign w_enter_p = w_pulse[0];
  assign w_clear_p = w_pulse[1];

  state_t      r_state;
  logic [15:0] r_user;
  logic [2:0]  r_count;
  logic        r_ready;
  logic        r_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_user  <= 16'h0000;
      r_count <= 3'd0;
      r_ready <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_bad <= 1'b0;
      // Dropping enable keeps the digits readable but withdraws ready.
      if (!enable) begin
        r_state <= S_IDLE;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ENTRY;
            r_user  <= 16'h0000;
            r_count <= 3'd0;
            r_ready <= 1'b0;
          end
          S_ENTRY: begin
            if (w_clear_p) begin
              r_user  <= 16'h0000;
              r_count <= 3'd0;
              r_ready <= 1'b0;
            end else if (w_enter_p && (r_count < 3'd4)) begin
              if (sw <= 4'd9) begin
                r_user  <= {r_user[11:0], sw};
                r_count <= r_count + 3'd1;
                if (r_count == 3'd3) begin
                  r_state <= S_DONE;
                  r_ready <= 1'b1;
                end
              end else begin
                r_bad <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (w_clear_p) begin
              r_state <= S_ENTRY;
              r_user  <= 16'h0000;
              r_count <= 3'd0;
              r_ready <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign userInput  = r_user;
  assign digitCount = r_count;
  assign inputReady = r_ready;
  assign badDigit   = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_input_entry.sv
`default_nettype none
// Bench for input_entry: directed scenarios plus random operations against a digit-queue model.
module tb_input_entry;

  localparam int DBC = 4;
  localparam int DBW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  sw;
  logic        btnEnter;
  logic        btnClear;
  logic [15:0] userInput;
  logic        inputReady;
  logic [2:0]  digitCount;
  logic        badDigit;

  always #5 clk = ~clk;

  input_entry #(.DB_CYCLES(DBC), .DB_W(DBW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sw(sw),
    .btnEnter(btnEnter), .btnClear(btnClear),
    .userInput(userInput), .inputReady(inputReady),
    .digitCount(digitCount), .badDigit(badDigit)
  );

  int checks = 0;
  int errors = 0;
  int bad_cnt = 0;
  int viol = 0;
  int bad_base = 0;
  int m_bad_exp = 0;
  logic [2:0] prev_dc = 3'd0;

  // Model: the accepted digits in order, and whether an entry round is open.
  int m_digits[$];
  bit m_active = 1'b0;

  always @(negedge clk) begin
    if (badDigit === 1'b1) bad_cnt++;
    if (digitCount > 3'd4) viol++;
    if (inputReady === 1'b1 && digitCount != 3'd4) viol++;
    if (prev_dc == 3'd3 && digitCount == 3'd4 && inputReady !== 1'b1) viol++;
    prev_dc = digitCount;
  end

  function automatic logic [15:0] m_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_op();
    bad_base  = bad_cnt;
    m_bad_exp = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".userInput"}, 32'(userInput), 32'(m_value()));
    chk({tag, ".digitCount"}, 32'(digitCount), 32'(m_digits.size()));
    chk({tag, ".inputReady"}, 32'(inputReady), 32'(m_active && m_digits.size() == 4));
    chk({tag, ".badDigit"}, 32'(bad_cnt - bad_base), 32'(m_bad_exp));
  endtask

  task automatic do_enter(input int v, input int hold, input string tag);
    begin_op();
    sw = 4'(v);
    btnEnter = 1'b1;
    cyc(hold);
    btnEnter = 1'b0;
    cyc(12);
    if (m_active && m_digits.size() < 4) begin
      if (v <= 9) m_digits.push_back(v);
      else m_bad_exp = 1;
    end
    check_all(tag);
  endtask

  task automatic do_clear(input string tag);
    begin_op();
    btnClear = 1'b1;
    cyc(10);
    btnClear = 1'b0;
    cyc(12);
    if (m_active) m_digits.delete();
    check_all(tag);
  endtask

  task automatic do_both(input int v, input string tag);
    begin_op();
    sw = 4'(v);
    btnEnter = 1'b1;
    btnClear = 1'b1;
    cyc(10);
    btnEnter = 1'b0;
    btnClear = 1'b0;
    cyc(12);
    if (m_active) m_digits.delete();
    check_all(tag);
  endtask

  task automatic set_enable(input bit b, input string tag);
    begin_op();
    enable = b;
    cyc(3);
    if (b && !m_active) begin
      m_active = 1'b1;
      m_digits.delete();
    end
    if (!b) m_active = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    sw = 4'd0;
    btnEnter = 1'b0;
    btnClear = 1'b0;
    begin_op();
    cyc(3);
    check_all("reset");
    rst = 1'b1;
    cyc(2);

    // Four digits, then a fifth enter that must be ignored.
    set_enable(1'b1, "en_rise");
    do_enter(1, 10, "d1");
    do_enter(2, 10, "d2");
    do_enter(3, 10, "d3");
    do_enter(4, 10, "d4");
    do_enter(5, 10, "d5_done");

    // Short glitch rejected, long hold accepted once.
    do_clear("clr1");
    begin_op();
    sw = 4'd6;
    btnEnter = 1'b1;
    cyc(2);
    btnEnter = 1'b0;
    cyc(12);
    check_all("glitch");
    do_enter(6, 20, "long_hold");

    // Non-BCD digit.
    do_clear("clr2");
    do_enter(7, 10, "d7");
    do_enter(8, 10, "d8");
    do_enter(11, 10, "bad_B");

    // Clear beats a simultaneous enter.
    do_clear("clr3");
    do_enter(1, 10, "d1b");
    do_enter(2, 10, "d2b");
    do_both(3, "both");

    // Enable drop in DONE.
    do_clear("clr4");
    do_enter(9, 10, "d9");
    do_enter(8, 10, "d8b");
    do_enter(7, 10, "d7b");
    do_enter(6, 10, "d6");
    begin_op();
    enable = 1'b0;
    cyc(1);
    chk("en_drop.ready_next", 32'(inputReady), 32'd0);
    cyc(2);
    m_active = 1'b0;
    check_all("en_drop");
    set_enable(1'b1, "en_rise2");

    // Asynchronous reset mid-entry.
    do_enter(1, 10, "r1");
    do_enter(2, 10, "r2");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async.userInput", 32'(userInput), 32'd0);
    chk("async.digitCount", 32'(digitCount), 32'd0);
    chk("async.inputReady", 32'(inputReady), 32'd0);
    chk("async.badDigit", 32'(badDigit), 32'd0);
    enable = 1'b0;
    cyc(2);
    rst = 1'b1;
    m_digits.delete();
    m_active = 1'b0;
    cyc(2);
    set_enable(1'b1, "post_rst_en");
    do_enter(3, 10, "p1");
    do_enter(0, 10, "p2");
    do_enter(5, 10, "p3");
    do_enter(9, 10, "p4");

    // Button held across reset release yields one accept.
    begin_op();
    sw = 4'd5;
    btnEnter = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    m_digits.delete();
    m_active = 1'b1;
    cyc(15);
    btnEnter = 1'b0;
    cyc(12);
    m_digits.push_back(5);
    check_all("held_rst");

    // Random operations.
    for (int n = 0; n < 30; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 5)      do_enter(int'($urandom_range(0, 15)), 10, "rnd_enter");
      else if (op <= 7) do_clear("rnd_clear");
      else if (op == 8) set_enable(!enable, "rnd_enable");
      else              do_both(int'($urandom_range(0, 15)), "rnd_both");
    end

    chk("invariants", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
